// File: rtl/fc_arith_pkg.sv
// Shared definitions for the flight-controller arithmetic datapath
// (sequential shift-add multiplier and restoring divider).
package fc_arith_pkg;

  // Signed-magnitude operand format: bit 31 is the sign, [30:0] the magnitude.
  localparam int SM_WIDTH   = 32;
  localparam int MAG_WIDTH  = 31;

  // Iterative engines run one step per enabled edge, steps 0..STEP_LAST.
  localparam int STEP_LAST  = 30;
  localparam int STEP_WIDTH = 5;

  // Common control sequence for the start/done handshake.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Pack a sign and a magnitude, suppressing negative zero.
  function automatic logic [SM_WIDTH-1:0] sm_pack(input logic                 sign,
                                                  input logic [MAG_WIDTH-1:0] mag);
    return {sign & (|mag), mag};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: bring in the next dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module div_step
  import fc_arith_pkg::*;
(
  input  logic [MAG_WIDTH-1:0] r,
  input  logic                 a_msb,
  input  logic [MAG_WIDTH-1:0] d,
  output logic [MAG_WIDTH-1:0] r_next,
  output logic                 q_bit
);

  logic [SM_WIDTH-1:0] trial;

  // The partial remainder is always below d, so the result of a successful
  // subtraction fits back into MAG_WIDTH bits; the wrap-around subtraction
  // on the low bits is therefore exact.
  always_comb begin
    trial  = {r, a_msb};
    q_bit  = (trial >= {1'b0, d});
    r_next = q_bit ? (trial[MAG_WIDTH-1:0] - d) : trial[MAG_WIDTH-1:0];
  end

endmodule

// File: rtl/div32.sv
// Sequential signed-magnitude 32-bit restoring divider. Fixed latency of 32
// enabled edges from the accepting edge to the done pulse, divide-by-zero
// included. Quotient truncates toward zero; remainder takes the dividend sign.
module div32
  import fc_arith_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                start,
  input  logic [SM_WIDTH-1:0] dividend,
  input  logic [SM_WIDTH-1:0] divisor,
  output logic [SM_WIDTH-1:0] quotient,
  output logic [SM_WIDTH-1:0] remainder,
  output logic                done,
  output logic                busy,
  output logic                div_by_zero
);

  state_t                 state_q, state_d;
  logic [MAG_WIDTH-1:0]   a_q, a_d;         // dividend magnitude, shifted out MSB first
  logic [MAG_WIDTH-1:0]   d_q, d_d;         // divisor magnitude
  // Partial remainder: architecturally 32 bits, but it never reaches d, so
  // its top bit is always zero and only the magnitude bits are kept.
  logic [MAG_WIDTH-1:0]   r_q, r_d;
  logic [MAG_WIDTH-1:0]   q_q, q_d;         // quotient bits, shifted in LSB first
  logic [STEP_WIDTH-1:0]  cnt_q, cnt_d;     // current RUN step
  logic                   qsign_q, qsign_d; // quotient sign
  logic                   rsign_q, rsign_d; // remainder sign (follows dividend)
  logic [SM_WIDTH-1:0]    quotient_q, quotient_d;
  logic [SM_WIDTH-1:0]    remainder_q, remainder_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   dbz_q, dbz_d;

  logic [MAG_WIDTH-1:0]   step_r_next;
  logic                   step_q_bit;

  div_step u_step (
    .r      (r_q),
    .a_msb  (a_q[MAG_WIDTH-1]),
    .d      (d_q),
    .r_next (step_r_next),
    .q_bit  (step_q_bit)
  );

  // Next-state and datapath updates; nothing moves (done included) when en is low.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    d_d         = d_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = done_q;
    busy_d      = busy_q;
    dbz_d       = dbz_q;

    if (en) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            qsign_d = dividend[SM_WIDTH-1] ^ divisor[SM_WIDTH-1];
            rsign_d = dividend[SM_WIDTH-1];
            a_d     = dividend[MAG_WIDTH-1:0];
            d_d     = divisor[MAG_WIDTH-1:0];
            r_d     = '0;
            q_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          a_d   = {a_q[MAG_WIDTH-2:0], 1'b0};
          r_d   = step_r_next;
          q_d   = {q_q[MAG_WIDTH-2:0], step_q_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == STEP_WIDTH'(STEP_LAST)) begin
            state_d = FINISH;
          end
        end
        FINISH: begin
          // A zero divisor still runs the full sequence so latency stays
          // fixed; its datapath result is simply replaced here.
          if (d_q == '0) begin
            quotient_d  = {qsign_q, {MAG_WIDTH{1'b1}}};
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            quotient_d  = sm_pack(qsign_q, q_q);
            remainder_d = sm_pack(rsign_q, r_q);
            dbz_d       = 1'b0;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      d_q         <= d_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_div32;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 0;

  div32 dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference division from plain integer arithmetic on the magnitudes.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    logic [30:0] ma, mb, qm, rm;
    logic        sq;
    ma = a[30:0];
    mb = b[30:0];
    sq = a[31] ^ b[31];
    if (mb == 31'd0) begin
      q = {sq, 31'h7FFF_FFFF};
      r = 32'd0;
      z = 1'b1;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
      q  = {sq & (qm != 31'd0), qm};
      r  = {a[31] & (rm != 31'd0), rm};
      z  = 1'b0;
    end
  endtask

  // Behavioural model: an accepted request completes 32 enabled edges later.
  logic [31:0] m_q, m_r, p_q, p_r, p_a, p_b;
  logic        m_done, m_busy, m_dbz, p_dbz;
  int          m_cnt;
  int          ops = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_q = 0; m_r = 0; m_done = 0; m_busy = 0; m_dbz = 0; m_cnt = 0;
    end else if (en) begin
      m_done = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 32) begin
          m_busy = 0;
          m_done = 1;
          m_q    = p_q;
          m_r    = p_r;
          m_dbz  = p_dbz;
          ops++;
          $display("op %0d: %08h / %08h -> q=%08h r=%08h dbz=%0b", ops, p_a, p_b, p_q, p_r, p_dbz);
        end
      end else if (start) begin
        m_busy = 1;
        m_cnt  = 0;
        p_a    = dividend;
        p_b    = divisor;
        ref_div(dividend, divisor, p_q, p_r, p_dbz);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp_quotient",  quotient,          m_q);
      check("cmp_remainder", remainder,         m_r);
      check("cmp_done",      32'(done),         32'(m_done));
      check("cmp_busy",      32'(busy),         32'(m_busy));
      check("cmp_dbz",       32'(div_by_zero),  32'(m_dbz));
    end
  end

  // Present a request at the current negedge; operands are scrambled after E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Count edges after E0 until done is seen; optional stall and stray start.
  task automatic wait_done(input int stall_at, input int stall_len, input int poke_at,
                           output int n);
    bit seen;
    seen = 0;
    n    = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      n++;
      start = (n == poke_at);
      if (n == stall_at) en = 1'b0;
      if (n == stall_at + stall_len) en = 1'b1;
      if (done) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d edges, required done", n);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int en_edges, input int stall_at, input int stall_len,
                        input int poke_at);
    int n;
    launch(a, b);
    wait_done(stall_at, stall_len, poke_at, n);
    check({name, "_edges"}, 32'(n), 32'(en_edges));
    check({name, "_q"},     quotient,  eq);
    check({name, "_r"},     remainder, er);
    check({name, "_dbz"},   32'(div_by_zero), 32'(ez));
  endtask

  task automatic count_dones(input string name, input int cycles, input int expected);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check(name, 32'(cnt), 32'(expected));
  endtask

  function automatic logic [31:0] rand_sm();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0: v = {v[31], 31'(v[4:0])};
      1: v = {v[31], 31'd0};
      2: v = {v[31], 31'(v[15:0])};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] tq, tr;
    logic        tz;

    nrst = 1'b0; en = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

    // Pin the model itself with hand-computed results.
    ref_div(32'd100, 32'd7, tq, tr, tz);
    check("model_100_7_q", tq, 32'h0000000E);
    check("model_100_7_r", tr, 32'h00000002);
    ref_div(32'h80000064, 32'd7, tq, tr, tz);
    check("model_neg_q", tq, 32'h8000000E);
    ref_div(32'd5, 32'd0, tq, tr, tz);
    check("model_dbz_q", tq, 32'h7FFFFFFF);
    check("model_dbz_z", 32'(tz), 32'd1);

    repeat (2) @(negedge clk);
    check("rst_quotient",  quotient,  32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_dbz",       32'(div_by_zero), 32'd0);
    #2 nrst = 1'b1;
    @(negedge clk);
    en     = 1'b1;
    cmp_on = 1;

    run_op("d100_7",   32'd100,      32'd7,          32'h0000000E, 32'h00000002, 1'b0, 32, 0, 0, 0);
    count_dones("single_done", 3, 0);
    run_op("dneg100_7", 32'h80000064, 32'd7,         32'h8000000E, 32'h80000002, 1'b0, 32, 0, 0, 0);
    run_op("d7_neg100", 32'd7,        32'h80000064,  32'h00000000, 32'h00000007, 1'b0, 32, 0, 0, 0);
    run_op("dmax_1",    32'h7FFFFFFF, 32'd1,         32'h7FFFFFFF, 32'h00000000, 1'b0, 32, 0, 0, 0);
    run_op("dnegzero",  32'h80000000, 32'h80000003,  32'h00000000, 32'h00000000, 1'b0, 32, 0, 0, 0);
    run_op("d5_0",      32'd5,        32'd0,         32'h7FFFFFFF, 32'h00000000, 1'b1, 32, 0, 0, 0);
    run_op("d9_3",      32'd9,        32'd3,         32'h00000003, 32'h00000000, 1'b0, 32, 0, 0, 0);

    // Stray start while busy must be ignored: one done only.
    run_op("poke",      32'd100,      32'd7,         32'h0000000E, 32'h00000002, 1'b0, 32, 0, 0, 5);
    count_dones("poke_no_extra_done", 40, 0);

    // Four disabled edges mid-RUN push done out by four edges.
    run_op("stall",     32'd100,      32'd7,         32'h0000000E, 32'h00000002, 1'b0, 36, 10, 4, 0);

    // Back-to-back: start presented while done is high.
    run_op("b2b_first", 32'd100,      32'd7,         32'h0000000E, 32'h00000002, 1'b0, 32, 0, 0, 0);
    run_op("b2b_second",32'h80000064, 32'd7,         32'h8000000E, 32'h80000002, 1'b0, 32, 0, 0, 0);

    // Reset in the middle of an operation clears everything at once.
    launch(32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_quotient",  quotient,  32'd0);
    check("mid_rst_remainder", remainder, 32'd0);
    check("mid_rst_busy",      32'(busy), 32'd0);
    check("mid_rst_done",      32'(done), 32'd0);
    @(negedge clk);
    #2 nrst = 1'b1;
    count_dones("mid_rst_no_done", 40, 0);
    run_op("after_rst", 32'd100,      32'd7,         32'h0000000E, 32'h00000002, 1'b0, 32, 0, 0, 0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 9) != 0);
      start    = ($urandom_range(0, 2) == 0);
      dividend = rand_sm();
      divisor  = rand_sm();
      if ($urandom_range(0, 799) == 0) begin
        #2 nrst = 1'b0;
        #2 nrst = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    en    = 1'b1;
    repeat (40) @(negedge clk);
    cmp_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
